// File: rtl/jump_charge_ctrl_pkg.sv
// Shared definitions for the jump charge controller, the kinematics unit
// and the power-bar display.
//   state_t      : controller sequencing states
//   V_W          : width of velocity / charge values
//   DEF_*        : default charge/hold/watchdog constants
package jump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHARGE,
    ST_JUMP,
    ST_LAND,
    ST_RELWAIT
  } state_t;

  localparam int V_W         = 11;
  localparam int DEF_STEP    = 4;
  localparam int DEF_VMIN    = 16;
  localparam int DEF_VMAX    = 508;
  localparam int DEF_HOLD    = 8;
  localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/jump_charge_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single level signal arriving from another
// clock domain (or from no clock at all).
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input level
//   q   : synchronised level, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      meta_q   <= d;
      stable_q <= meta_q;
    end
  end

  assign q = stable_q;

endmodule

// File: rtl/jump_charge_ctrl.sv
// Jump charge controller: converts a press-and-hold of the jump button into
// a launch velocity and sequences one jump of the kinematics unit.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   btn       : debounced jump-button level
//   tick      : one-cycle charge-rate strobe
//   i_done    : done flag from the kinematics unit (asynchronous)
//   o_jump_en : kinematics enable, low clears the consumer
//   o_v_init  : launch velocity, held until the next launch
//   o_charge  : live charge level for the power bar
//   o_landed  : high during the post-landing hold window
//   o_timeout : one-cycle pulse when the watchdog aborts a jump
module jump_charge_ctrl
  import jump_pkg::*;
#(
  parameter int STEP    = DEF_STEP,
  parameter int VMIN    = DEF_VMIN,
  parameter int VMAX    = DEF_VMAX,
  parameter int HOLD    = DEF_HOLD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn,
  input  logic           tick,
  input  logic           i_done,
  output logic           o_jump_en,
  output logic [V_W-1:0] o_v_init,
  output logic [V_W-1:0] o_charge,
  output logic           o_landed,
  output logic           o_timeout
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_t         state_q, state_d;
  logic [V_W-1:0] charge_q, charge_d;
  logic [V_W-1:0] v_init_q, v_init_d;
  logic           jump_en_q, jump_en_d;
  logic           landed_q, landed_d;
  logic           timeout_q, timeout_d;
  logic [15:0]    wdog_q, wdog_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           done_s;
  logic [V_W:0]   charge_sum;
  logic [V_W-1:0] charge_sat;

  sync_2ff u_done_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_done),
    .q   (done_s)
  );

  // One extra bit of headroom so the sum cannot wrap before the clamp.
  assign charge_sum = {1'b0, charge_q} + (V_W+1)'(STEP);
  assign charge_sat = (charge_sum > (V_W+1)'(VMAX)) ? V_W'(VMAX) : charge_sum[V_W-1:0];

  always_comb begin
    state_d   = state_q;
    charge_d  = charge_q;
    v_init_d  = v_init_q;
    jump_en_d = jump_en_q;
    landed_d  = landed_q;
    timeout_d = 1'b0;
    wdog_d    = wdog_q;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE: begin
        jump_en_d = 1'b0;
        landed_d  = 1'b0;
        charge_d  = '0;
        if (btn) state_d = ST_CHARGE;
      end
      ST_CHARGE: begin
        // Release takes priority over a coincident tick.
        if (!btn) begin
          if (charge_q >= V_W'(VMIN)) begin
            v_init_d  = charge_q;
            jump_en_d = 1'b1;
            wdog_d    = '0;
            state_d   = ST_JUMP;
          end else begin
            charge_d = '0;
            state_d  = ST_IDLE;
          end
        end else if (tick) begin
          charge_d = charge_sat;
        end
      end
      ST_JUMP: begin
        jump_en_d = 1'b1;
        if (done_s) begin
          landed_d = 1'b1;
          hold_d   = '0;
          state_d  = ST_LAND;
        end else if (wdog_q == 16'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          jump_en_d = 1'b0;
          state_d   = ST_RELWAIT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ST_LAND: begin
        if (hold_q == HW'(HOLD - 1)) begin
          jump_en_d = 1'b0;
          landed_d  = 1'b0;
          charge_d  = '0;
          state_d   = ST_RELWAIT;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RELWAIT: begin
        // A button still held from the last charge must be let go first.
        jump_en_d = 1'b0;
        landed_d  = 1'b0;
        if (!btn) begin
          charge_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        jump_en_d = 1'b0;
        landed_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      charge_q  <= '0;
      v_init_q  <= '0;
      jump_en_q <= 1'b0;
      landed_q  <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      charge_q  <= charge_d;
      v_init_q  <= v_init_d;
      jump_en_q <= jump_en_d;
      landed_q  <= landed_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
      hold_q    <= hold_d;
    end
  end

  assign o_jump_en = jump_en_q;
  assign o_v_init  = v_init_q;
  assign o_charge  = charge_q;
  assign o_landed  = landed_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_jump_charge_ctrl.sv
module tb_jump_charge_ctrl;

  localparam int STEP    = 4;
  localparam int VMIN    = 16;
  localparam int VMAX    = 508;
  localparam int HOLD    = 8;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn = 1'b0;
  logic        tick = 1'b0;
  logic        i_done = 1'b0;
  logic        o_jump_en;
  logic [10:0] o_v_init;
  logic [10:0] o_charge;
  logic        o_landed;
  logic        o_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int last_v = 0;   // model: most recent launch velocity

  jump_charge_ctrl #(
    .STEP(STEP), .VMIN(VMIN), .VMAX(VMAX), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .tick(tick), .i_done(i_done),
    .o_jump_en(o_jump_en), .o_v_init(o_v_init), .o_charge(o_charge),
    .o_landed(o_landed), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (o_jump_en !== 1'b0 || o_v_init !== 11'd0 || o_charge !== 11'd0 ||
        o_landed !== 1'b0 || o_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: en=%b v=%0d chg=%0d land=%b to=%b required all 0",
               tag, o_jump_en, o_v_init, o_charge, o_landed, o_timeout);
    end
  endtask

  // Press, deliver nticks charge ticks, release. Model: charge = min(ticks*STEP, VMAX);
  // launch iff charge >= VMIN.
  task automatic charge_release(input int nticks, input bit rand_gaps,
                                input bit tick_at_rel, output bit launched);
    int exp_c;
    int got;
    exp_c = 0;
    got   = 0;
    btn = 1'b1; tick = 1'b0;
    step();
    while (got < nticks) begin
      tick = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (tick) begin
        got++;
        exp_c = (exp_c + STEP > VMAX) ? VMAX : exp_c + STEP;
        n_cmp++;
        if (o_charge !== 11'(exp_c)) begin
          n_bad++;
          $display("FAIL charge_tick%0d: got %0d required %0d", got, o_charge, exp_c);
        end
      end
    end
    btn = 1'b0; tick = tick_at_rel;
    step();
    tick = 1'b0;
    launched = (exp_c >= VMIN);
    if (launched) last_v = exp_c;
    n_cmp++;
    if (o_jump_en !== launched || o_v_init !== 11'(last_v) ||
        o_charge !== 11'(launched ? exp_c : 0)) begin
      n_bad++;
      $display("FAIL release(%0d ticks): en=%b v=%0d chg=%0d required en=%b v=%0d chg=%0d",
               nticks, o_jump_en, o_v_init, o_charge, launched, last_v,
               launched ? exp_c : 0);
    end
    $display("release after %0d ticks: charge %0d launched=%b v_init=%0d",
             nticks, exp_c, launched, o_v_init);
  endtask

  // Consumer reports done; expect 2 sync cycles + 1 state update, then HOLD cycles landed.
  task automatic finish_jump();
    int k;
    int n;
    i_done = 1'b1;
    k = 0;
    while (!o_landed && k < 10) begin
      step();
      k++;
    end
    n_cmp++;
    if (k !== 3) begin
      n_bad++;
      $display("FAIL landed_latency: got %0d cycles required 3", k);
    end
    n = 0;
    while (o_landed && n < 20) begin
      n_cmp++;
      if (o_jump_en !== 1'b1) begin
        n_bad++;
        $display("FAIL en_during_land: got %b required 1", o_jump_en);
      end
      n++;
      step();
    end
    n_cmp++;
    if (n !== HOLD || o_jump_en !== 1'b0 || o_charge !== 11'd0) begin
      n_bad++;
      $display("FAIL land_window: cycles=%0d en=%b chg=%0d required %0d, 0, 0",
               n, o_jump_en, o_charge, HOLD);
    end
    i_done = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (o_jump_en !== 1'b0 || o_charge !== 11'd0 || o_v_init !== 11'(last_v)) begin
      n_bad++;
      $display("FAIL after_jump: en=%b chg=%0d v=%0d required 0, 0, %0d",
               o_jump_en, o_charge, o_v_init, last_v);
    end
    $display("jump complete: landed %0d cycles, v_init=%0d", n, o_v_init);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    last_v = 0;
    step();
    check_all_zero("idle_after_reset");
    $display("reset checked");
  endtask

  task automatic test_discard();
    bit l;
    charge_release(3, 1'b0, 1'b0, l);
    repeat (2) step();
    check_all_zero("discard_idle");
  endtask

  task automatic test_launch();
    bit l;
    charge_release(10, 1'b0, 1'b0, l);
    if (l) finish_jump();
  endtask

  task automatic test_boundary();
    bit l;
    charge_release(4, 1'b0, 1'b0, l);   // exactly VMIN launches
    if (l) finish_jump();
  endtask

  task automatic test_saturate();
    bit l;
    charge_release(200, 1'b0, 1'b0, l);
    if (l) finish_jump();
  endtask

  task automatic test_release_tick();
    bit l;
    charge_release(5, 1'b0, 1'b1, l);   // 20, coincident tick ignored
    if (l) finish_jump();
  endtask

  task automatic test_timeout();
    bit l;
    int k;
    charge_release(7, 1'b0, 1'b0, l);
    btn = 1'b1; tick = 1'b1;            // ignored while jumping
    k = 0;
    while (!o_timeout && k < 200) begin
      step();
      k++;
    end
    n_cmp++;
    if (k !== TIMEOUT || o_jump_en !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: at %0d en=%b required %0d, 0", k, o_jump_en, TIMEOUT);
    end
    step();
    n_cmp++;
    if (o_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_width: got %b required 0", o_timeout);
    end
    repeat (10) begin
      step();
      n_cmp++;
      if (o_jump_en !== 1'b0 || o_landed !== 1'b0 || o_charge !== 11'(last_v)) begin
        n_bad++;
        $display("FAIL relwait_hold: en=%b land=%b chg=%0d required 0, 0, %0d",
                 o_jump_en, o_landed, o_charge, last_v);
      end
    end
    btn = 1'b0; tick = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (o_jump_en !== 1'b0 || o_charge !== 11'd0 || o_v_init !== 11'(last_v)) begin
      n_bad++;
      $display("FAIL timeout_idle: en=%b chg=%0d v=%0d required 0, 0, %0d",
               o_jump_en, o_charge, o_v_init, last_v);
    end
    $display("timeout after %0d cycles, v_init=%0d", k, o_v_init);
  endtask

  task automatic test_reset_mid();
    bit l;
    charge_release(10, 1'b0, 1'b0, l);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_all_zero("reset_mid_jump");
    rst = 1'b0;
    last_v = 0;
    step();
    charge_release(8, 1'b0, 1'b0, l);
    i_done = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (o_landed !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_land: got %b required 1", o_landed);
    end
    btn = 1'b1;
    rst = 1'b1;
    step();
    check_all_zero("reset_mid_land");
    i_done = 1'b0;                      // consumer cleared by enable low
    rst = 1'b0;
    last_v = 0;
    step();                             // held button enters charging
    for (int i = 1; i <= 5; i++) begin
      tick = 1'b1;
      step();
      n_cmp++;
      if (o_charge !== 11'(i * STEP)) begin
        n_bad++;
        $display("FAIL recharge_tick%0d: got %0d required %0d", i, o_charge, i * STEP);
      end
    end
    tick = 1'b0; btn = 1'b0;
    step();
    last_v = 5 * STEP;
    n_cmp++;
    if (o_jump_en !== 1'b1 || o_v_init !== 11'(last_v)) begin
      n_bad++;
      $display("FAIL recharge_launch: en=%b v=%0d required 1, %0d", o_jump_en, o_v_init, last_v);
    end
    $display("reset mid-jump / mid-land checked, relaunch v_init=%0d", o_v_init);
    finish_jump();
  endtask

  task automatic test_random();
    bit l;
    for (int it = 0; it < 8; it++) begin
      charge_release(int'($urandom_range(0, 40)), 1'b1, 1'($urandom_range(0, 1)), l);
      if (l) finish_jump();
      else repeat (2) step();
    end
  endtask

  initial begin
    test_reset();
    test_discard();
    test_launch();
    test_boundary();
    test_saturate();
    test_release_tick();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
